// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader.
package boot_pkg;

    localparam int unsigned BOOT_WORDS     = 32;
    localparam int unsigned BOOT_ADDR_W    = 5;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input, memory-load output and boot status signals of the loader.
interface boot_loader_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);

    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              load_mem_en;
    logic [ADDR_W-1:0] load_mem_addr;
    logic [DATA_W-1:0] load_mem_data;
    logic              cpu_rst_n;
    logic              done;
    logic              error;

    // Loader side.
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, load_mem_en, load_mem_addr, load_mem_data,
               cpu_rst_n, done, error
    );

    // Byte source / boot controller side.
    modport master (
        output start, in_valid, in_data,
        input  in_ready, load_mem_en, load_mem_addr, load_mem_data,
               cpu_rst_n, done, error
    );

endinterface

// File: rtl/boot_word_asm.sv
// Little-endian byte-to-word assembler: byte 0 of each group lands in the LSB lane.
module boot_word_asm
    import boot_pkg::*;
#(
    parameter int unsigned BYTES = BYTES_PER_WORD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [7:0]         byte_in,
    output logic [8*BYTES-1:0] word_next,
    output logic               last
);

    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    // Only the upper BYTES-1 lanes need storage; the final byte completes the
    // word combinationally so the consumer can register it on the same edge.
    logic [8*(BYTES-1)-1:0] word_q;
    logic [CNT_W-1:0]       byte_cnt;

    assign word_next = {byte_in, word_q};
    assign last      = accept && (byte_cnt == CNT_W'(BYTES - 1));

    // Shift accepted bytes in from the top and track the lane position.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q   <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            word_q   <= word_next[8*BYTES-1:8];
            byte_cnt <= last ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Serial program loader: assembles words, writes them to CPU memory, verifies
// the trailing checksum and then releases the CPU from reset.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned WORDS  = BOOT_WORDS,
    parameter int unsigned ADDR_W = BOOT_ADDR_W,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.slave  bus
);

    boot_state_t       state;
    boot_state_t       state_next;
    logic [ADDR_W-1:0] word_cnt;
    logic [7:0]        sum;
    logic [7:0]        sum_next;
    logic              ready;
    logic              accept;
    logic              go;
    logic              word_accept;
    logic              word_last;
    logic              last_word;
    logic [DATA_W-1:0] word_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Handshake and status outputs decode straight from the state register.
    assign ready             = (state == ST_RECV) || (state == ST_CHECK);
    assign bus.in_ready      = ready;
    assign bus.load_mem_en   = (state == ST_WRITE);
    assign bus.done          = (state == ST_DONE);
    assign bus.cpu_rst_n     = (state == ST_DONE);
    assign bus.error         = (state == ST_ERROR);
    assign bus.load_mem_addr = addr_q;
    assign bus.load_mem_data = data_q;

    assign accept      = bus.in_valid && ready;
    assign go          = bus.start && ((state == ST_IDLE) || (state == ST_ERROR));
    assign word_accept = accept && (state == ST_RECV);
    assign sum_next    = sum + bus.in_data;
    assign last_word   = (word_cnt == ADDR_W'(WORDS - 1));

    boot_word_asm #(
        .BYTES (BYTES_PER_WORD)
    ) u_word_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (go),
        .accept    (word_accept),
        .byte_in   (bus.in_data),
        .word_next (word_next),
        .last      (word_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (go) state_next = ST_RECV;
            ST_RECV:  if (word_last) state_next = ST_WRITE;
            ST_WRITE: state_next = last_word ? ST_CHECK : ST_RECV;
            ST_CHECK: if (accept) state_next = (sum_next == 8'h00) ? ST_DONE : ST_ERROR;
            ST_DONE:  state_next = ST_DONE;
            ST_ERROR: if (go) state_next = ST_RECV;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Word counter and running byte checksum.
    always_ff @(posedge clk) begin
        if (rst || go) begin
            word_cnt <= '0;
            sum      <= '0;
        end else begin
            if (word_accept) begin
                sum <= sum_next;
            end
            if ((state == ST_WRITE) && !last_word) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // Capture address and completed word as the last byte arrives so both are
    // valid during WRITE and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (word_last) begin
            addr_q <= word_cnt;
            data_q <= word_next;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: scenario table plus corner-case sequences,
// with writes checked against an expected-write queue built from the image.
module tb_boot_loader;

    localparam int unsigned WORDS = 32;

    logic clk;
    logic rst;

    boot_loader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    boot_loader #(
        .WORDS  (32),
        .ADDR_W (5),
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned wr_count;

    typedef struct {
        logic [31:0] base;
        logic [7:0]  ck_xor;
        int unsigned max_gap;
        logic        exp_done;
        logic        exp_error;
        logic        exp_cpu;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [41:0] outs();
        return {bus.in_ready, bus.load_mem_en, bus.load_mem_addr, bus.load_mem_data,
                bus.cpu_rst_n, bus.done, bus.error};
    endfunction

    // Memory-write monitor: every strobe must match the next expected write.
    always @(negedge clk) begin : mon
        wr_t w;
        if (bus.load_mem_en === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h", bus.load_mem_addr, bus.load_mem_data);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", 64'(bus.load_mem_addr), 64'(w.addr));
                chk("wr_data", 64'(bus.load_mem_data), 64'(w.data));
            end
        end
    end

    task automatic do_reset(input int unsigned cycles, input bit with_valid, input bit with_start);
        rst          = 1'b1;
        bus.in_valid = with_valid;
        bus.in_data  = 8'hA5;
        bus.start    = with_start;
        repeat (cycles) begin
            @(negedge clk);
            chk("reset_hold", 64'(outs()), 64'd0);
        end
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("idle_after_reset", 64'(outs()), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit ok;
        bit rdy;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = 1'b0;
        for (int unsigned n = 0; n < 20 && !ok; n++) begin
            rdy = bus.in_ready;
            @(negedge clk);
            ok = rdy;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout actual=no_accept required=accept byte=%0h", b);
        end
    endtask

    // Reference: word i = base+i sent LSB first, checksum = two's complement of
    // the byte sum (optionally corrupted); image is good iff total sum is 0 mod 256.
    task automatic run_load(input logic [31:0] base, input int unsigned nwords,
                            input logic [7:0] ck_xor, input int unsigned max_gap,
                            input bit poke_start, output bit good);
        logic [7:0]  sum;
        logic [7:0]  ck;
        logic [7:0]  tot;
        logic [31:0] w;
        wr_t         e;
        sum  = 8'h00;
        good = 1'b0;
        exp_q.delete();
        wr_count = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ready_after_start", 64'(bus.in_ready), 64'd1);
        chk("error_clear_on_start", 64'(bus.error), 64'd0);
        for (int unsigned i = 0; i < nwords; i++) begin
            w      = base + i;
            e.addr = 5'(i);
            e.data = w;
            exp_q.push_back(e);
            for (int unsigned b = 0; b < 4; b++) begin
                if (poke_start && i == 5 && b == 2) begin
                    bus.start = 1'b1;
                    @(negedge clk);
                    bus.start = 1'b0;
                end
                send_byte(w[8*b +: 8], $urandom_range(max_gap, 0));
                sum = sum + w[8*b +: 8];
            end
            chk("write_latency", 64'(bus.load_mem_en), 64'd1);
        end
        if (nwords == WORDS) begin
            ck = (8'h00 - sum) ^ ck_xor;
            send_byte(ck, $urandom_range(max_gap, 0));
            tot  = sum + ck;
            good = (tot == 8'h00);
            chk("done", 64'(bus.done), 64'(good));
            chk("error", 64'(bus.error), 64'(!good));
            chk("cpu_rst_n", 64'(bus.cpu_rst_n), 64'(good));
            chk("in_ready_end", 64'(bus.in_ready), 64'd0);
            chk("write_count", 64'(wr_count), 64'(nwords));
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit good;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        wr_count     = 0;

        // Reset held 3 cycles with in_valid and start asserted: reset wins.
        do_reset(3, 1'b1, 1'b1);

        vecs[0] = '{32'h1000_0000, 8'h00, 0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{$urandom,      8'h00, 3, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{$urandom,      8'h80, 3, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h1000_0000, 8'h01, 0, 1'b0, 1'b1, 1'b0};

        foreach (vecs[k]) begin
            do_reset(1, 1'b0, 1'b0);
            run_load(vecs[k].base, WORDS, vecs[k].ck_xor, vecs[k].max_gap, 1'b0, good);
            chk("tbl_done", 64'(bus.done), 64'(vecs[k].exp_done));
            chk("tbl_error", 64'(bus.error), 64'(vecs[k].exp_error));
            chk("tbl_cpu_rst_n", 64'(bus.cpu_rst_n), 64'(vecs[k].exp_cpu));
        end

        // Restart from ERROR with a correct image.
        run_load($urandom, WORDS, 8'h00, 2, 1'b0, good);
        chk("restart_done", 64'(bus.done), 64'd1);
        chk("restart_cpu", 64'(bus.cpu_rst_n), 64'd1);

        // Reset from DONE drops cpu_rst_n; then a mid-load reset after word 10.
        do_reset(1, 1'b0, 1'b0);
        run_load(32'h1000_0000, 11, 8'h00, 1, 1'b0, good);
        do_reset(1, 1'b1, 1'b0);
        chk("midreset_writes", 64'(wr_count), 64'd11);
        run_load($urandom, WORDS, 8'h00, 3, 1'b0, good);
        chk("after_midreset_done", 64'(bus.done), 64'd1);

        // Start pulses during RECV and DONE are ignored.
        do_reset(1, 1'b0, 1'b0);
        run_load(32'h1000_0000, WORDS, 8'h00, 1, 1'b1, good);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_in_done", 64'(outs() & 42'h3_0000_0000_07), 64'(42'h0_0000_0000_06));
        chk("done_hold", 64'(bus.done), 64'd1);

        do_reset(1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
